// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared constants and state encoding for the arithmetic blocks
//
// Contents:
//   ARITH_WIDTH  default operand width shared by the multiplier and divider
//   div_state_t  divider FSM encoding (ST_IDLE, ST_CALC, ST_DONE)
package arith_pkg;

  localparam int ARITH_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division step
//
// Ports:
//   r       in   WIDTH  restored partial remainder from the previous step
//   q_msb   in   1      dividend bit shifted into the partial remainder
//   d       in   WIDTH  divisor
//   r_next  out  WIDTH  restored partial remainder after this step
//   q_bit   out  1      quotient bit produced by this step
module div_step
  import arith_pkg::*;
#(
  parameter int WIDTH = ARITH_WIDTH
) (
  input  logic [WIDTH-1:0] r,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] r_next,
  output logic             q_bit
);

  // R' carries the extra bit so the compare never overflows. A restored R
  // is always below D (or is a prefix of the dividend when D is zero), so it
  // fits in WIDTH bits and the subtraction result does too whenever it is kept.
  logic [WIDTH:0]   r_shift;
  logic [WIDTH-1:0] diff;

  always_comb begin
    r_shift = {r, q_msb};
    diff    = r_shift[WIDTH-1:0] - d;
    q_bit   = (r_shift >= {1'b0, d});
    r_next  = q_bit ? diff : r_shift[WIDTH-1:0];
  end

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - iterative restoring unsigned divider, one quotient bit per clock
//
// Ports:
//   clk          in   1      system clock, rising edge
//   rst          in   1      asynchronous active-high reset
//   start        in   1      begin a division; honoured only while busy is low
//   dividend     in   WIDTH  unsigned dividend, sampled with start
//   divisor      in   WIDTH  unsigned divisor, sampled with start
//   busy         out  1      operation in progress (WIDTH cycles)
//   done         out  1      one-cycle pulse: results valid
//   quotient     out  WIDTH  held until the next completion
//   remainder    out  WIDTH  held until the next completion
//   div_by_zero  out  1      last completed operation had a zero divisor
module seq_divider
  import arith_pkg::*;
#(
  parameter int WIDTH = ARITH_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  div_state_t       state, state_next;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] d_reg;
  logic [WIDTH-1:0] r_reg;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] r_next;
  logic             q_bit;
  logic [WIDTH-1:0] q_shift;
  logic             accept;
  logic             last_step;

  div_step #(.WIDTH(WIDTH)) u_step (
    .r      (r_reg),
    .q_msb  (q_reg[WIDTH-1]),
    .d      (d_reg),
    .r_next (r_next),
    .q_bit  (q_bit)
  );

  assign q_shift = {q_reg[WIDTH-2:0], q_bit};

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last_step  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = ST_CALC;
        end
      end
      ST_CALC: begin
        if (cnt == LAST_STEP) begin
          last_step  = 1'b1;
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        // A start held through the done cycle chains straight into CALC.
        if (start) begin
          accept     = 1'b1;
          state_next = ST_CALC;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      q_reg       <= '0;
      d_reg       <= '0;
      r_reg       <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        q_reg <= dividend;
        d_reg <= divisor;
        r_reg <= '0;
        cnt   <= '0;
      end else if (state == ST_CALC) begin
        q_reg <= q_shift;
        r_reg <= r_next;
        cnt   <= cnt + 1'b1;
        if (last_step) begin
          quotient    <= q_shift;
          remainder   <= r_next;
          div_by_zero <= (d_reg == '0);
        end
      end
    end
  end

  assign busy = (state == ST_CALC);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - directed self-checking bench for seq_divider
module tb_seq_divider;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int checks = 0;
  int errors = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  // Launch one operation from IDLE and wait for done; lat counts falling
  // edges after the accepting edge, busy_cnt the busy cycles seen on the way.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       output int lat, output int busy_cnt);
    @(negedge clk);
    start = 1'b1;
    dividend = a;
    divisor = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    busy_cnt = 0;
    while (!done && lat < 40) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, div_by_zero} !== 3'b000 || quotient !== 8'd0 || remainder !== 8'd0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b dbz=%b q=%0d r=%0d, want all zero",
               busy, done, div_by_zero, quotient, remainder);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int lat, bc;
    do_op(8'd15, 8'd3, lat, bc);
    checks++;
    if (lat !== 9) begin
      errors++;
      $display("FAIL basic_latency: got %0d, want 9", lat);
    end
    checks++;
    if (bc !== 8) begin
      errors++;
      $display("FAIL basic_busy_cycles: got %0d, want 8", bc);
    end
    checks++;
    if (quotient !== 8'd5 || remainder !== 8'd0 || div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL basic_15_3: q=%0d r=%0d dbz=%b, want 5 0 0", quotient, remainder, div_by_zero);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || quotient !== 8'd5) begin
      errors++;
      $display("FAIL done_pulse_hold: done=%b q=%0d, want 0 5", done, quotient);
    end
  endtask

  task automatic test_vectors();
    logic [W-1:0] va [4] = '{8'd100, 8'd255, 8'd255, 8'd7};
    logic [W-1:0] vb [4] = '{8'd7,   8'd255, 8'd2,   8'd10};
    logic [W-1:0] eq [4] = '{8'd14,  8'd1,   8'd127, 8'd0};
    logic [W-1:0] er [4] = '{8'd2,   8'd0,   8'd1,   8'd7};
    int lat, bc;
    for (int i = 0; i < 4; i++) begin
      do_op(va[i], vb[i], lat, bc);
      checks++;
      if (lat !== 9 || quotient !== eq[i] || remainder !== er[i] || div_by_zero !== 1'b0) begin
        errors++;
        $display("FAIL vec_%0d_%0d: lat=%0d q=%0d r=%0d dbz=%b, want 9 %0d %0d 0",
                 va[i], vb[i], lat, quotient, remainder, div_by_zero, eq[i], er[i]);
      end
    end
  endtask

  task automatic test_div_zero();
    int lat, bc;
    do_op(8'd200, 8'd0, lat, bc);
    checks++;
    if (lat !== 9 || quotient !== 8'd255 || remainder !== 8'd200 || div_by_zero !== 1'b1) begin
      errors++;
      $display("FAIL div_zero: lat=%0d q=%0d r=%0d dbz=%b, want 9 255 200 1",
               lat, quotient, remainder, div_by_zero);
    end
    do_op(8'd9, 8'd3, lat, bc);
    checks++;
    if (quotient !== 8'd3 || remainder !== 8'd0 || div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL dbz_clear: q=%0d r=%0d dbz=%b, want 3 0 0", quotient, remainder, div_by_zero);
    end
  endtask

  task automatic test_ignored_start();
    int n, dones;
    @(negedge clk);
    start = 1'b1;
    dividend = 8'd60;
    divisor = 8'd4;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1;
    dividend = 8'd50;
    divisor = 8'd5;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    dones = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done !== 1'b1 || quotient !== 8'd15 || remainder !== 8'd0) begin
      errors++;
      $display("FAIL ignored_start: done=%b q=%0d r=%0d, want 1 15 0", done, quotient, remainder);
    end
    repeat (12) begin
      @(negedge clk);
      if (done) dones++;
    end
    checks++;
    if (dones !== 0) begin
      errors++;
      $display("FAIL no_second_done: got %0d extra done pulses, want 0", dones);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc, gap;
    do_op(8'd20, 8'd4, lat, bc);
    checks++;
    if (quotient !== 8'd5 || remainder !== 8'd0) begin
      errors++;
      $display("FAIL b2b_first: q=%0d r=%0d, want 5 0", quotient, remainder);
    end
    // Still inside the done cycle: hold start across the DONE edge.
    start = 1'b1;
    dividend = 8'd64;
    divisor = 8'd8;
    @(negedge clk);
    start = 1'b0;
    gap = 1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept: busy=%b, want 1", busy);
    end
    while (!done && gap < 40) begin
      @(negedge clk);
      gap++;
    end
    checks++;
    if (gap !== 9 || quotient !== 8'd8 || remainder !== 8'd0) begin
      errors++;
      $display("FAIL b2b_second: gap=%0d q=%0d r=%0d, want 9 8 0", gap, quotient, remainder);
    end
  endtask

  task automatic test_async_reset();
    int lat, bc, dones;
    @(negedge clk);
    start = 1'b1;
    dividend = 8'd90;
    divisor = 8'd9;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, div_by_zero} !== 3'b000 || quotient !== 8'd0 || remainder !== 8'd0) begin
      errors++;
      $display("FAIL async_reset: busy=%b done=%b dbz=%b q=%0d r=%0d, want all zero",
               busy, done, div_by_zero, quotient, remainder);
    end
    #1 rst = 1'b0;
    dones = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) dones++;
    end
    checks++;
    if (dones !== 0) begin
      errors++;
      $display("FAIL reset_no_done: got %0d done pulses, want 0", dones);
    end
    do_op(8'd90, 8'd9, lat, bc);
    checks++;
    if (lat !== 9 || quotient !== 8'd10 || remainder !== 8'd0) begin
      errors++;
      $display("FAIL after_reset_90_9: lat=%0d q=%0d r=%0d, want 9 10 0", lat, quotient, remainder);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_div_zero();
    test_ignored_start();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
